// File: rtl/avalon_pipelined_master_pkg.sv
// Shared defaults and width helpers for the Avalon pipelined master and its sub-units.
package avalon_pipelined_master_pkg;

  localparam int DEF_ADDR_WIDTH      = 32;
  localparam int DEF_DATA_WIDTH      = 32;
  localparam int DEF_MAX_OUTSTANDING = 4;

  // Width of a counter that must hold every value 0..max_count inclusive.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

  // Width of an index into a storage of `depth` entries (never zero).
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/avalon_pipelined_master_if.sv
// Avalon-MM pipelined-read bus between the load/store master and its slave.
interface avalon_pipelined_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic [DATA_WIDTH-1:0]   writedata;
  logic                    read;
  logic                    write;
  logic                    waitrequest;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;

  modport master (
    output address, byteenable, writedata, read, write,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, writedata, read, write,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/avalon_pipelined_master_chk.sv
// Protocol and invariant assertions for the Avalon pipelined master.
module avalon_pipelined_master_chk #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CW              = 3
) (
  input logic                    clk,
  input logic                    rst,
  input logic                    req_valid,
  input logic                    req_load,
  input logic                    req_store,
  input logic [CW-1:0]           credits,
  input logic [CW-1:0]           inflight,
  input logic [ADDR_WIDTH-1:0]   address,
  input logic [DATA_WIDTH/8-1:0] byteenable,
  input logic [DATA_WIDTH-1:0]   writedata,
  input logic                    read,
  input logic                    write,
  input logic                    waitrequest,
  input logic                    readdatavalid
);

  a_credit_bound: assert property (@(posedge clk) disable iff (rst)
    credits <= CW'(MAX_OUTSTANDING));

  a_no_load_store: assert property (@(posedge clk) disable iff (rst)
    req_valid |-> !(req_load && req_store));

  a_cmd_stable: assert property (@(posedge clk) disable iff (rst)
    ((read || write) && waitrequest) |=>
      ($stable(address) && $stable(byteenable) && $stable(writedata) &&
       $stable(read) && $stable(write)));

  a_rdv_expected: assert property (@(posedge clk) disable iff (rst)
    readdatavalid |-> (inflight != CW'(0)));

endmodule

// File: rtl/avalon_pipelined_master_rsp_fifo.sv
// In-order read-response FIFO; head data and flags come straight from storage registers.
module avalon_pipelined_master_rsp_fifo
  import avalon_pipelined_master_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic [CW-1:0]         count_nxt_s;
  logic                  full_r;
  logic                  empty_r;
  logic                  do_push_s;
  logic                  do_pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? PW'(0) : ptr + PW'(1);
  endfunction

  assign do_push_s = push & ~full_r;
  assign do_pop_s  = pop & ~empty_r;
  assign pop_data  = mem_r[rd_ptr_r];
  assign full      = full_r;
  assign empty     = empty_r;

  // Occupancy update for push, pop or both.
  always_comb begin
    count_nxt_s = count_r;
    case ({do_push_s, do_pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, occupancy and registered full/empty flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CW'(DEPTH));
      empty_r <= (count_nxt_s == CW'(0));
      if (do_push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (do_pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/avalon_pipelined_master.sv
// Avalon-MM pipelined-read master for the load/store unit: one command register,
// credit-limited outstanding reads and an in-order response FIFO; writes are posted.
module avalon_pipelined_master
  import avalon_pipelined_master_pkg::*;
#(
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_load,
  input  logic                      req_store,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH/8-1:0]   req_be,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_data,
  avalon_pipelined_master_if.master av,
  output logic                      busy
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int CW       = cnt_width(MAX_OUTSTANDING);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [BE_WIDTH-1:0]   be;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  load;
    logic                  store;
  } avalon_req_t;

  avalon_req_t   req_s;
  avalon_req_t   cmd_r;
  logic [CW-1:0] credits_r;
  logic [CW-1:0] credits_nxt_s;
  logic [CW-1:0] inflight_r;
  logic [CW-1:0] inflight_nxt_s;
  logic          cmd_active_s;
  logic          cmd_accept_s;
  logic          read_accept_s;
  logic          req_fire_s;
  logic          load_fire_s;
  logic          rsp_pop_s;
  logic          rdv_take_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;

  assign req_s = '{addr: req_addr, be: req_be, wdata: req_wdata,
                   load: req_load, store: req_store};

  assign cmd_active_s  = cmd_r.load | cmd_r.store;
  assign cmd_accept_s  = cmd_active_s & ~av.waitrequest;
  assign read_accept_s = cmd_r.load & ~av.waitrequest;

  // A new request may overwrite the command register in the very cycle the old one is taken.
  assign req_ready   = (~cmd_active_s | ~av.waitrequest) & (~req_load | (credits_r != CW'(0)));
  assign req_fire_s  = req_valid & req_ready;
  assign load_fire_s = req_fire_s & req_load;

  assign rsp_valid  = ~fifo_empty_s;
  assign rsp_pop_s  = rsp_valid & rsp_ready;
  assign rdv_take_s = av.readdatavalid & (inflight_r != CW'(0));

  assign av.address    = cmd_r.addr;
  assign av.byteenable = cmd_r.be;
  assign av.writedata  = cmd_r.wdata;
  assign av.read       = cmd_r.load;
  assign av.write      = cmd_r.store;

  assign busy = cmd_active_s | (inflight_r != CW'(0)) | ~fifo_empty_s;

  // Command register; only the read/write strobes are reset, the payload is don't-care when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_r.load  <= 1'b0;
      cmd_r.store <= 1'b0;
    end else if (req_fire_s) begin
      cmd_r <= req_s;
    end else if (cmd_accept_s) begin
      cmd_r.load  <= 1'b0;
      cmd_r.store <= 1'b0;
    end
  end

  // Credits bound reads issued but not yet popped, so the FIFO can always absorb readdatavalid.
  always_comb begin
    credits_nxt_s = credits_r;
    case ({load_fire_s, rsp_pop_s})
      2'b10:   credits_nxt_s = credits_r - CW'(1);
      2'b01:   credits_nxt_s = credits_r + CW'(1);
      default: credits_nxt_s = credits_r;
    endcase
  end

  // Reads accepted by the slave whose data has not yet returned.
  always_comb begin
    inflight_nxt_s = inflight_r;
    case ({read_accept_s, rdv_take_s})
      2'b10:   inflight_nxt_s = inflight_r + CW'(1);
      2'b01:   inflight_nxt_s = inflight_r - CW'(1);
      default: inflight_nxt_s = inflight_r;
    endcase
  end

  // Credit and in-flight counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits_r  <= CW'(MAX_OUTSTANDING);
      inflight_r <= CW'(0);
    end else begin
      credits_r  <= credits_nxt_s;
      inflight_r <= inflight_nxt_s;
    end
  end

  avalon_pipelined_master_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MAX_OUTSTANDING)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rdv_take_s & ~fifo_full_s),
    .push_data (av.readdata),
    .pop       (rsp_pop_s),
    .pop_data  (rsp_data),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  avalon_pipelined_master_chk #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .DATA_WIDTH      (DATA_WIDTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CW              (CW)
  ) u_chk (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_load      (req_load),
    .req_store     (req_store),
    .credits       (credits_r),
    .inflight      (inflight_r),
    .address       (cmd_r.addr),
    .byteenable    (cmd_r.be),
    .writedata     (cmd_r.wdata),
    .read          (cmd_r.load),
    .write         (cmd_r.store),
    .waitrequest   (av.waitrequest),
    .readdatavalid (av.readdatavalid)
  );

endmodule

// File: tb/tb_avalon_pipelined_master.sv
// Scoreboard bench: request-level memory model predicts read data and command order;
// a behavioural Avalon slave and a response monitor check the DUT against it.
module tb_avalon_pipelined_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_load = 1'b0;
  logic          req_store = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [BW-1:0] req_be = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          busy;

  avalon_pipelined_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) av_bus ();

  avalon_pipelined_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
    .req_store(req_store), .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .av(av_bus.master), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          load;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] data;
  } cmd_t;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } pend_t;

  int            checks = 0;
  int            errors = 0;
  int            cycle  = 0;
  logic [DW-1:0] model_mem [logic [AW-1:0]];
  logic [DW-1:0] slave_mem [logic [AW-1:0]];
  logic [DW-1:0] exp_q [$];
  cmd_t          cmd_q [$];
  pend_t         pend_q [$];
  int            last_due = 0;
  int            wait_mode = 0;
  int            wait_hold = 0;
  logic          wr_tog = 1'b0;
  int            lat_min = 1;
  int            lat_max = 1;
  int            rsp_mode = 1;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r = old;
    for (int i = 0; i < BW; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_val(a);
  endfunction

  function automatic logic [DW-1:0] slave_rd(input logic [AW-1:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : init_val(a);
  endfunction

  task automatic preset(input logic [AW-1:0] a, input logic [DW-1:0] d);
    model_mem[a] = d;
    slave_mem[a] = d;
  endtask

  // Behavioural slave: waitrequest pattern, in-order delayed read data, command scoreboard.
  initial begin
    cmd_t  c;
    pend_t p;
    int    lat;
    av_bus.waitrequest   = 1'b0;
    av_bus.readdatavalid = 1'b0;
    av_bus.readdata      = '0;
    forever begin
      @(posedge clk); #1;
      case (wait_mode)
        1: av_bus.waitrequest = 1'($urandom_range(0, 1));
        2: begin wr_tog = ~wr_tog; av_bus.waitrequest = wr_tog; end
        3: begin
          av_bus.waitrequest = (wait_hold > 0);
          if (wait_hold > 0) wait_hold--;
        end
        default: av_bus.waitrequest = 1'b0;
      endcase
      if (pend_q.size() > 0 && pend_q[0].due <= cycle) begin
        av_bus.readdatavalid = 1'b1;
        av_bus.readdata      = pend_q[0].data;
        void'(pend_q.pop_front());
      end else begin
        av_bus.readdatavalid = 1'b0;
        av_bus.readdata      = $urandom;
      end
      @(negedge clk);
      if (rst) begin
        pend_q.delete();
        last_due = 0;
      end else if ((av_bus.read || av_bus.write) && !av_bus.waitrequest) begin
        if (cmd_q.size() == 0) begin
          check("unexpected_cmd", 64'(cmd_q.size()), 64'd1);
        end else begin
          c = cmd_q.pop_front();
          check("cmd_kind", {63'd0, av_bus.read}, {63'd0, c.load});
          check("cmd_addr", 64'(av_bus.address), 64'(c.addr));
          check("cmd_be", 64'(av_bus.byteenable), 64'(c.be));
          if (!c.load) check("cmd_wdata", 64'(av_bus.writedata), 64'(c.data));
        end
        if (av_bus.write)
          slave_mem[av_bus.address] = merge(slave_rd(av_bus.address), av_bus.writedata,
                                            av_bus.byteenable);
        if (av_bus.read) begin
          lat    = $urandom_range(lat_min, lat_max);
          p.data = slave_rd(av_bus.address);
          p.due  = (cycle + lat > last_due + 1) ? cycle + lat : last_due + 1;
          last_due = p.due;
          pend_q.push_back(p);
        end
      end
    end
  end

  // Response monitor: drives consumer backpressure and pops the expected-data queue.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rsp_mode)
        0:       rsp_ready = 1'b0;
        2:       rsp_ready = 1'($urandom_range(0, 1));
        default: rsp_ready = 1'b1;
      endcase
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) check("unexpected_rsp", 64'(exp_q.size()), 64'd1);
        else                   check("rsp_data", 64'(rsp_data), 64'(exp_q.pop_front()));
      end
    end
  end

  // One request cycle; records the expected outcome at the request-level model if accepted.
  task automatic drive_req(input logic ld, input logic st, input logic [AW-1:0] a,
                           input logic [BW-1:0] be, input logic [DW-1:0] d, output logic fired);
    cmd_t c;
    @(posedge clk); #1;
    req_valid = 1'b1; req_load = ld; req_store = st;
    req_addr = a; req_be = be; req_wdata = d;
    @(negedge clk);
    fired = req_valid & req_ready;
    if (fired) begin
      c.load = ld; c.addr = a; c.be = be; c.data = d;
      cmd_q.push_back(c);
      if (ld) exp_q.push_back(model_rd(a));
      if (st) model_mem[a] = merge(model_rd(a), d, be);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    @(negedge clk);
  endtask

  task automatic issue(input logic ld, input logic st, input logic [AW-1:0] a,
                       input logic [BW-1:0] be, input logic [DW-1:0] d);
    logic f = 1'b0;
    int   n = 0;
    while (!f && n < 50) begin
      drive_req(ld, st, a, be, d, f);
      n++;
    end
    if (!f) check("issue_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    rsp_mode = 1;
    idle_cycle();
    while ((busy || exp_q.size() != 0 || pend_q.size() != 0) && n < 500) begin
      idle_cycle();
      n++;
    end
    check({name, "_busy"}, {63'd0, busy}, 64'd0);
    check({name, "_rsp_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_cmd_left"}, 64'(cmd_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic f;
    logic any;
    int   n;

    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_av_read", {63'd0, av_bus.read}, 64'd0);
    check("rst_av_write", {63'd0, av_bus.write}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("rst_credits", 64'(dut.credits_r), 64'(MO));

    // Single load, two-cycle slave latency, response one cycle after readdatavalid.
    preset(32'h0000_0100, 32'hDEAD_BEEF);
    lat_min = 2; lat_max = 2; rsp_mode = 1; wait_mode = 0;
    issue(1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0);
    n = 0;
    idle_cycle();
    while (!av_bus.readdatavalid && n < 10) begin idle_cycle(); n++; end
    check("single_rdv_seen", {63'd0, av_bus.readdatavalid}, 64'd1);
    idle_cycle();
    check("single_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    check("single_rsp_data", 64'(rsp_data), 64'hDEAD_BEEF);
    idle_cycle();
    check("single_busy_after_pop", {63'd0, busy}, 64'd0);

    // Four back-to-back loads fill the credits; the fifth waits for a pop.
    for (int i = 0; i < 5; i++) preset(32'h300 + 32'(4 * i), 32'hA0 + 32'(i));
    lat_min = 5; lat_max = 5; rsp_mode = 0;
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b1, 1'b0, 32'h300 + 32'(4 * i), 4'hF, 32'h0, f);
      check("b2b_fire", {63'd0, f}, 64'd1);
    end
    any = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_req(1'b1, 1'b0, 32'h310, 4'hF, 32'h0, f);
      any |= f;
    end
    check("fifth_stalled", {63'd0, any}, 64'd0);
    check("fifth_ready_low", {63'd0, req_ready}, 64'd0);
    check("fifo_holds_rsp", {63'd0, rsp_valid}, 64'd1);
    rsp_mode = 1;
    drive_req(1'b1, 1'b0, 32'h310, 4'hF, 32'h0, f);
    rsp_mode = 0;
    check("fifth_pop_cycle", {63'd0, f}, 64'd0);
    drive_req(1'b1, 1'b0, 32'h310, 4'hF, 32'h0, f);
    check("fifth_after_pop", {63'd0, f}, 64'd1);
    wait_idle("b2b");

    // Store held under three cycles of waitrequest.
    wait_mode = 3;
    issue(1'b0, 1'b1, 32'h200, 4'h3, 32'h1234);
    wait_hold = 3;
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      check("st_hold_write", {63'd0, av_bus.write}, 64'd1);
      check("st_hold_wait", {63'd0, av_bus.waitrequest}, 64'd1);
      check("st_hold_addr", 64'(av_bus.address), 64'h200);
      check("st_hold_be", 64'(av_bus.byteenable), 64'h3);
      check("st_hold_data", 64'(av_bus.writedata), 64'h1234);
    end
    idle_cycle();
    check("st_accept_write", {63'd0, av_bus.write}, 64'd1);
    check("st_accept_wait", {63'd0, av_bus.waitrequest}, 64'd0);
    idle_cycle();
    check("st_write_dropped", {63'd0, av_bus.write}, 64'd0);
    check("st_no_rsp", {63'd0, rsp_valid}, 64'd0);
    wait_mode = 0;
    wait_idle("store");

    // Mixed load/store/load with waitrequest toggling each cycle.
    wait_mode = 2; lat_min = 1; lat_max = 4;
    issue(1'b1, 1'b0, 32'h400, 4'hF, 32'h0);
    issue(1'b0, 1'b1, 32'h404, 4'h5, 32'hCAFE_F00D);
    issue(1'b1, 1'b0, 32'h404, 4'hF, 32'h0);
    wait_idle("mixed");
    check("mixed_credits", 64'(dut.credits_r), 64'(MO));
    wait_mode = 0;

    // Credit accounting around simultaneous pop and load.
    lat_min = 1; lat_max = 1; rsp_mode = 0;
    for (int i = 0; i < 4; i++) issue(1'b1, 1'b0, 32'h500 + 32'(4 * i), 4'hF, 32'h0);
    repeat (6) idle_cycle();
    check("cr_zero", 64'(dut.credits_r), 64'd0);
    rsp_mode = 1;
    drive_req(1'b1, 1'b0, 32'h520, 4'hF, 32'h0, f);
    check("cr_pop_no_load", {63'd0, f}, 64'd0);
    drive_req(1'b1, 1'b0, 32'h520, 4'hF, 32'h0, f);
    rsp_mode = 0;
    check("cr_pop_and_load", {63'd0, f}, 64'd1);
    drive_req(1'b1, 1'b0, 32'h524, 4'hF, 32'h0, f);
    check("cr_unchanged", {63'd0, f}, 64'd1);
    drive_req(1'b1, 1'b0, 32'h528, 4'hF, 32'h0, f);
    check("cr_exhausted", {63'd0, f}, 64'd0);
    check("cr_ready_low", {63'd0, req_ready}, 64'd0);
    wait_idle("credit");

    // Reset with two reads in flight.
    lat_min = 20; lat_max = 20; rsp_mode = 0;
    issue(1'b1, 1'b0, 32'h600, 4'hF, 32'h0);
    issue(1'b1, 1'b0, 32'h604, 4'hF, 32'h0);
    idle_cycle();
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    cmd_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_av_read", {63'd0, av_bus.read}, 64'd0);
    check("mid_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("mid_rst_credits", 64'(dut.credits_r), 64'(MO));
    check("mid_rst_busy", {63'd0, busy}, 64'd0);

    // Randomised traffic over a small aliasing address window.
    wait_mode = 1; lat_min = 1; lat_max = 6; rsp_mode = 2;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 6) begin
        logic ld = 1'($urandom_range(0, 1));
        drive_req(ld, ~ld, 32'h700 + 32'(4 * $urandom_range(0, 7)), 4'($urandom),
                  $urandom, f);
      end else begin
        idle_cycle();
      end
    end
    wait_mode = 0;
    wait_idle("random");
    check("random_credits", 64'(dut.credits_r), 64'(MO));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
